// File: rtl/sys_input_conditioner_if.sv
// Pin-side inputs and conditioned control outputs of sys_input_conditioner.
// The master drives the raw board pins; the slave is the conditioner itself.
interface sys_input_conditioner_if;
  logic [3:0]  KEY_n;
  logic [17:0] SW_raw;
  logic        REPEAT_EN;
  logic [3:0]  key_level;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic        step_pulse;
  logic [17:0] sw_sync;
  logic        sw_change;

  modport master (
    output KEY_n, SW_raw, REPEAT_EN,
    input  key_level, key_press, key_release, step_pulse, sw_sync, sw_change
  );

  modport slave (
    input  KEY_n, SW_raw, REPEAT_EN,
    output key_level, key_press, key_release, step_pulse, sw_sync, sw_change
  );
endinterface

// File: rtl/sys_input_conditioner.sv
// DE2 board-input front end: synchronizes keys and switches, debounces the keys,
// and turns KEY[0] into a single-step enable with optional auto-repeat.
module sys_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                   SYS_clk,
  input  logic                   SYS_rst,
  sys_input_conditioner_if.slave io
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [3:0]  key_meta_n, key_sync_n, key_sample;
  logic [17:0] sw_meta, sw_sync, sw_prev;
  logic        sw_change;

  logic [3:0]      key_level, key_level_next, key_toggle;
  logic [3:0]      key_press, key_release;
  logic [DB_W-1:0] db_cnt [4];

  logic [1:0]       state;
  logic [RPT_W-1:0] rpt_cnt;
  logic             step_pulse;

  // Two-flop synchronizers; keys idle high (released) out of reset.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      key_meta_n <= '1;
      key_sync_n <= '1;
      sw_meta    <= '0;
      sw_sync    <= '0;
    end else begin
      key_meta_n <= io.KEY_n;
      key_sync_n <= key_meta_n;
      sw_meta    <= io.SW_raw;
      sw_sync    <= sw_meta;
    end
  end

  assign key_sample = ~key_sync_n;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    key_toggle = '0;
    for (int i = 0; i < 4; i++)
      key_toggle[i] = (key_sample[i] != key_level[i]) && (db_cnt[i] == DB_LAST);
  end

  assign key_level_next = key_level ^ key_toggle;

  // A counter runs only while the sample disagrees with the accepted level.
  // NOTE: the counter array is reset so a key held across reset needs a full fresh window.
  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      key_level   <= key_level_next;
      key_press   <= key_toggle & ~key_level;
      key_release <= key_toggle & key_level;
      for (int i = 0; i < 4; i++) begin
        if ((key_sample[i] == key_level[i]) || key_toggle[i]) db_cnt[i] <= '0;
        else                                                  db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
    end
  end

  // Step FSM. Release is judged on the level being written this edge, so a
  // repeat that would coincide with the release strobe is suppressed.
  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      state      <= S_IDLE;
      rpt_cnt    <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          rpt_cnt <= '0;
          if (key_press[0]) begin
            step_pulse <= 1'b1;
            state      <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (!key_level_next[0]) begin
            state   <= S_IDLE;
            rpt_cnt <= '0;
          end else if (!io.REPEAT_EN) begin
            rpt_cnt <= '0;
          end else if (rpt_cnt == DELAY_LAST) begin
            step_pulse <= 1'b1;
            rpt_cnt    <= '0;
            state      <= S_REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!key_level_next[0]) begin
            state   <= S_IDLE;
            rpt_cnt <= '0;
          end else if (!io.REPEAT_EN) begin
            state   <= S_DELAY;
            rpt_cnt <= '0;
          end else if (rpt_cnt == PERIOD_LAST) begin
            step_pulse <= 1'b1;
            rpt_cnt    <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          rpt_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_rst) begin
    if (SYS_rst) begin
      sw_prev   <= '0;
      sw_change <= 1'b0;
    end else begin
      sw_prev   <= sw_sync;
      sw_change <= (sw_sync != sw_prev);
    end
  end

  assign io.key_level   = key_level;
  assign io.key_press   = key_press;
  assign io.key_release = key_release;
  assign io.step_pulse  = step_pulse;
  assign io.sw_sync     = sw_sync;
  assign io.sw_change   = sw_change;

endmodule

// File: doc/sys_input_conditioner.md
# sys_input_conditioner

Board-input front end for the MIPS system top level. It takes the raw DE2 push-buttons (active-low, bouncing) and slide switches (asynchronous) and produces clean, synchronous, active-high controls for the system core:
- debounced key levels
- one-cycle press/release strobes
- a single-step clock-enable pulse with optional auto-repeat
- synchronized switch values with a change strobe

It sits between the board pins and the `system` core, replacing direct use of raw `KEY`/`SW`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable samples required to accept a new key level (20 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles from accepted KEY[0] press to the first auto-repeat step.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent auto-repeat steps.

Ports:
- `SYS_clk` input 1: the single clock (`CLOCK_50`); all logic is on its rising edge.
- `SYS_rst` input 1: asynchronous, active-high reset.
- `KEY_n` input 4: raw push-buttons, active-low, asynchronous.
- `SW_raw` input 18: raw slide switches, asynchronous.
- `REPEAT_EN` input 1: enables auto-repeat on `step_pulse`. Sampled synchronously.
- `key_level` output 4: debounced key state, 1 = pressed.
- `key_press` output 4: one-cycle strobe when `key_level[i]` goes 0→1.
- `key_release` output 4: one-cycle strobe when `key_level[i]` goes 1→0.
- `step_pulse` output 1: one-cycle single-step enable derived from KEY[0].
- `sw_sync` output 18: switches after a 2-flop synchronizer.
- `sw_change` output 1: one-cycle strobe when any bit of `sw_sync` changes.

## Operation
Synchronizers:
- Each `KEY_n` bit passes through 2 flops, then is inverted to active-high. The key flops reset to 1 (released).
- Each `SW_raw` bit passes through 2 flops, reset to 0.

Per-key debounce (4 independent instances):
- Each instance has a stable level `key_level[i]` and a counter of width `$clog2(DEBOUNCE_CYCLES)`.
- Synced sample equals `key_level[i]`: the counter clears.
- Sample differs: the counter increments. When it reaches `DEBOUNCE_CYCLES-1` with the sample still differing, the following occur on the same edge:
  - `key_level[i]` toggles;
  - the counter clears;
  - `key_press[i]` or `key_release[i]` is registered high for exactly one cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` samples produces no output change.

Step FSM (KEY[0] only), states IDLE, DELAY, REPEAT, with one shared counter:
- IDLE: on `key_press[0]`, assert `step_pulse` for one cycle. Go to DELAY and clear the counter.
- DELAY:
  - `key_level[0]`=0 → IDLE.
  - Else if `REPEAT_EN`=0 → stay, with the counter held at 0.
  - Else the counter counts. At `REPEAT_DELAY-1`, assert `step_pulse`, clear the counter, go to REPEAT.
- REPEAT:
  - `key_level[0]`=0 → IDLE.
  - `REPEAT_EN`=0 → DELAY with the counter cleared.
  - Else at `REPEAT_PERIOD-1`, assert `step_pulse` and clear the counter.
- Release always takes priority over a coincident repeat pulse: no pulse is emitted in that cycle.

Switch change:
- `sw_change` = registered (`sw_sync` != previous `sw_sync`). It goes high one cycle after `sw_sync` updates.

## Timing
Reset values:
- `key_level`=0, `key_press`=0, `key_release`=0, `step_pulse`=0, `sw_sync`=0, `sw_change`=0.
- FSM in IDLE, all counters 0.
- The previous-value register for `sw_sync` resets to 0.

Latencies:
- Key latency: a raw edge first sampled at clock edge E gives the strobe and the new `key_level` visible after edge E+1+`DEBOUNCE_CYCLES`.
- `step_pulse` on press is registered from `key_press[0]`, so it is 1 cycle after `key_press[0]`.
- Auto-repeat steps:
  - the first repeat comes `REPEAT_DELAY` cycles after the press step;
  - subsequent repeats every `REPEAT_PERIOD` cycles.
- Switch path: `sw_sync` is 2 cycles after a raw change; `sw_change` is 3 cycles after.

Other timing rules:
- Each strobe is exactly 1 cycle wide. Strobes are never back-to-back on the same key bit, because the minimum spacing is `DEBOUNCE_CYCLES`.
- Simultaneous key events are independent: all four bits may strobe in the same cycle.
- Reset asserted mid-debounce or mid-repeat:
  - all state returns immediately to reset values;
  - a key still held when reset is released is accepted after the full debounce time and yields a fresh `key_press`.
- Counters never wrap. Each saturates at its terminal count, which always triggers a clear.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- Reset, then `KEY_n`=4'hF and `SW_raw`=0 held for 20 cycles → all outputs 0, no strobes.
- `KEY_n[1]` driven low at edge 0 and held → `key_press[1]` high for exactly the cycle after edge 5. `key_level[1]`=1 from then on. No other bits change.
- `KEY_n[2]` bounce pattern low-3-cycles, high-1, low-held → a single `key_press[2]`, 5 cycles after the start of the final low run. Likewise a single `key_release` on a bouncy release.
- `REPEAT_EN`=1, KEY[0] held 40 cycles after acceptance → `step_pulse` at press+1, then +10, then every 5 cycles (7 pulses total). Release → no further pulses and FSM in IDLE.
- `REPEAT_EN`=0, KEY[0] held 40 cycles → exactly one `step_pulse`. Asserting `SYS_rst` mid-hold, then deasserting → a second `key_press[0]` and `step_pulse` after debounce.
- `SW_raw` changed 18'h00000→18'h2A5A5 → `sw_sync`=18'h2A5A5 after 2 cycles and `sw_change` one cycle wide after 3 cycles. An unchanged `SW_raw` → no `sw_change`.
